// File: rtl/frame_buffer_responder.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_responder
// Purpose  : Double-buffered RGB pixel store serving read-modify-write traffic
//            with fixed latency, plus a one-cycle display scan-out port.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_responder #(
  parameter int CLKWAIT = 2,
  parameter int ADDR_W  = 19,
  parameter int DEPTH   = 307200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pixel_number,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        write_r,
  input  logic [7:0]        write_g,
  input  logic [7:0]        write_b,
  output logic [7:0]        read_r,
  output logic [7:0]        read_g,
  output logic [7:0]        read_b,
  input  logic              frame_ready,
  output logic              busy,
  output logic              swap_done,
  output logic              proto_err,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [7:0]        disp_r,
  output logic [7:0]        disp_g,
  output logic [7:0]        disp_b
);

  localparam int                c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RENDER = 2'd0,
    S_DRAIN  = 2'd1,
    S_SWAP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_busy;
  logic                w_swap_done;
  logic                r_bank_sel;
  logic                r_proto_err;
  logic [CLKWAIT-1:0]  r_vld;
  logic [ADDR_W-1:0]   r_addr [CLKWAIT];
  logic [23:0]         r_bank0 [DEPTH];
  logic [23:0]         r_bank1 [DEPTH];
  logic [23:0]         r_rd_data;
  logic [23:0]         r_disp_data;

  logic                w_accept;
  logic                w_fin_vld;
  logic [ADDR_W-1:0]   w_fin_addr;
  logic                w_commit;
  logic [23:0]         w_wdata;
  logic                w_rd_vld;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [23:0]         w_rd_mem;
  logic [23:0]         w_rd_data;
  logic [23:0]         w_disp_mem;
  logic [23:0]         w_disp_data;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < c_depth;
  endfunction

  assign w_accept   = read && !w_busy;
  assign w_fin_vld  = r_vld[CLKWAIT-1];
  assign w_fin_addr = r_addr[CLKWAIT-1];
  assign w_wdata    = {write_r, write_g, write_b};
  assign w_commit   = write && w_fin_vld && in_range(w_fin_addr);

  // Read data is registered one edge before presentation, so it is fetched
  // from the stage just ahead of the final one (or straight from the port).
  generate
    if (CLKWAIT == 1) begin : g_rd_direct
      assign w_rd_vld  = w_accept;
      assign w_rd_addr = pixel_number;
    end else begin : g_rd_stage
      assign w_rd_vld  = r_vld[CLKWAIT-2];
      assign w_rd_addr = r_addr[CLKWAIT-2];
    end
  endgenerate

  assign w_rd_mem    = r_bank_sel ? r_bank1[w_rd_addr[c_idx_w-1:0]]
                                  : r_bank0[w_rd_addr[c_idx_w-1:0]];
  assign w_rd_data   = !in_range(w_rd_addr) ? 24'h0 :
                       (w_commit && (w_fin_addr == w_rd_addr)) ? w_wdata : w_rd_mem;
  assign w_disp_mem  = r_bank_sel ? r_bank0[disp_addr[c_idx_w-1:0]]
                                  : r_bank1[disp_addr[c_idx_w-1:0]];
  assign w_disp_data = in_range(disp_addr) ? w_disp_mem : 24'h0;

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_swap_done = 1'b0;
    case (r_state)
      S_RENDER: begin
        w_busy = 1'b0;
        if (frame_ready) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_vld == '0) w_state_nxt = S_SWAP;
      end
      S_SWAP: begin
        w_swap_done = 1'b1;
        w_state_nxt = S_RENDER;
      end
      default: w_state_nxt = S_RENDER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RENDER;
      r_bank_sel  <= 1'b0;
      r_proto_err <= 1'b0;
      r_vld       <= '0;
      r_rd_data   <= 24'h0;
      r_disp_data <= 24'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld[0] <= w_accept;
      for (int i = 1; i < CLKWAIT; i++) r_vld[i] <= r_vld[i-1];
      if (r_state == S_SWAP) r_bank_sel <= ~r_bank_sel;
      if ((read && w_busy) || (write && !w_fin_vld)) r_proto_err <= 1'b1;
      if (w_rd_vld) r_rd_data <= w_rd_data;
      r_disp_data <= w_disp_data;
    end
  end

  always_ff @(posedge clk) begin
    r_addr[0] <= pixel_number;
    for (int i = 1; i < CLKWAIT; i++) r_addr[i] <= r_addr[i-1];
  end

  // Pixel storage carries no reset; only the pipeline valids gate commits.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (r_bank_sel) r_bank1[w_fin_addr[c_idx_w-1:0]] <= w_wdata;
      else            r_bank0[w_fin_addr[c_idx_w-1:0]] <= w_wdata;
    end
  end

  assign {read_r, read_g, read_b} = r_rd_data;
  assign {disp_r, disp_g, disp_b} = r_disp_data;
  assign busy      = w_busy;
  assign swap_done = w_swap_done;
  assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: doc/frame_buffer_responder.md
# frame_buffer_responder

Double-buffered pixel store that serves the alpha blender's read-modify-write traffic. It captures the pixel address on each read and returns the stored RGB a fixed CLKWAIT cycles later. It commits the blended RGB to the same address when the delayed write strobe arrives. On frame_ready it drains outstanding requests and swaps the render and display banks; a separate 1-cycle display port feeds scan-out.

## Interface
- CLKWAIT, 2: cycles from read request to write strobe; also the read-data latency (≥1).
- ADDR_W, 19: pixel address width.
- DEPTH, 307200: pixels per bank.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_number  in  ADDR_W  address of the read request.
- read  in  1  read request, one pixel per asserted cycle.
- write  in  1  write strobe; commits the read issued CLKWAIT cycles earlier.
- write_r / write_g / write_b  in  8 each  blended colour to commit.
- read_r / read_g / read_b  out  8 each  stored colour, registered.
- frame_ready  in  1  render frame complete (pulse).
- busy  out  1  high in DRAIN and SWAP; upstream holds read low.
- swap_done  out  1  one-cycle pulse in SWAP.
- proto_err  out  1  sticky protocol-violation flag.
- disp_addr  in  ADDR_W  scan-out address.
- disp_r / disp_g / disp_b  out  8 each  display-bank colour, registered.

## Operation
- Storage: two banks of DEPTH×24 bits, with no content reset. bank_sel selects the render bank; the other bank is the display bank.
- Request pipeline: CLKWAIT stages of {valid, address}. Stage 0 loads {read && !busy, pixel_number}. A read while busy is dropped and sets proto_err.
- Read data for a request accepted in cycle t is presented on read_r/g/b during cycle t+CLKWAIT. It reflects every write committed on or before the rising edge that ends cycle t+CLKWAIT-1.
  - A same-address write committing at that edge is forwarded (write-first).
- Write: when write=1 in cycle t+CLKWAIT and the final stage is valid, write_r/g/b commit to the final-stage address at the end of that cycle. A write with the final stage invalid is ignored and sets proto_err. A valid final stage with write=0 is not an error; no commit occurs.
- Address ≥ DEPTH: the read returns 0 and its write is dropped. Neither sets proto_err.
- Display port: disp_r/g/b at cycle n+1 = display-bank contents at disp_addr sampled in cycle n. Out-of-range returns 0.
- FSM:
  - RENDER: frame_ready → DRAIN.
  - DRAIN: when all pipeline stages are invalid → SWAP; otherwise stay.
  - SWAP: swap_done=1 for one cycle; bank_sel toggles on the exiting edge → RENDER.
  - frame_ready in DRAIN or SWAP is ignored.
- Reset: FSM=RENDER, bank_sel=0, pipeline invalid (pending writes discarded), read_r/g/b=0, disp_r/g/b=0, busy=0, swap_done=0, proto_err=0. proto_err clears only on reset.

## Timing
- Read latency is exactly CLKWAIT cycles. Throughput is one request per cycle.
- Back-to-back reads to the same address at t and t+1, with CLKWAIT=2: the second read sees the first read's write via forwarding.
- frame_ready in cycle f: busy=1 from f+1. With an empty pipeline, DRAIN is f+1, SWAP is f+2, and the display port uses the new bank for disp_addr sampled at f+3.
- DRAIN length = cycles until the last accepted read's write cycle has passed, i.e. ≤ CLKWAIT+1 cycles.
- Display reads in the SWAP cycle still use the old bank.

## Test plan
- Reset, then read address 3 of bank 0 → after CLKWAIT=2 cycles read_r/g/b return the preloaded {10,20,30}. Write {40,50,60} in that cycle. A second read of address 3 returns {40,50,60}.
- Consecutive reads of address 5 at t and t+1, first write {1,2,3} → the second read returns {1,2,3} (forwarding), not the old value.
- frame_ready with 2 reads in flight → busy rises, DRAIN holds until both writes commit, swap_done pulses once. disp_addr=3 then returns {40,50,60}, and render reads hit the old display bank.
- Read asserted while busy → no data, no commit, proto_err=1 and stays 1. Stray write with no request → proto_err=1 and memory unchanged.
- pixel_number=DEPTH (16, with DEPTH=16) → read returns 0, the write is dropped, address 0 is unchanged.
- Assert reset mid-pipeline with a write pending → outputs 0, bank_sel=0, the pending write is never committed, proto_err=0.
